// File: rtl/rect_draw.sv
// Streams every pixel of an axis-aligned rectangle (column-major) to a framebuffer write port.
// Optional screen-edge clipping of the write strobe is enabled by defining RECT_DRAW_CLIP_EN.
module rect_draw #(
    parameter int unsigned         COORD_W  = 10,
    parameter int unsigned         COLOR_W  = 3,
    parameter logic [COLOR_W-1:0]  BG_COLOR = '0,
    parameter int unsigned         SCREEN_W = 160,
    parameter int unsigned         SCREEN_H = 120
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [COORD_W-1:0] width_in,
    input  logic [COORD_W-1:0] height_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               erase,
    output logic               busy,
    output logic               done,
    output logic               writeEn,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COLOR_W-1:0] color
);

    localparam int unsigned SUM_W = COORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] w_q, w_d, h_q, h_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [COORD_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
    logic               busy_q, busy_d, done_q, done_d, we_q, we_d;

    logic               col_wrap;
    logic               last_pix;
    logic [COORD_W-1:0] cx_n, cy_n;
    logic [SUM_W-1:0]   pix_x, pix_y;
    logic               pix_vis;

    // Scan position following the current one, and the unwrapped coordinate of the pixel to present next
    always_comb begin
        col_wrap = (cy_q == h_q - COORD_W'(1));
        last_pix = col_wrap && (cx_q == w_q - COORD_W'(1));
        cy_n     = col_wrap ? '0 : cy_q + COORD_W'(1);
        cx_n     = col_wrap ? cx_q + COORD_W'(1) : cx_q;
        if (state_q == ST_IDLE) begin
            pix_x = SUM_W'(x_in);
            pix_y = SUM_W'(y_in);
        end else begin
            pix_x = SUM_W'(x_q) + SUM_W'(cx_n);
            pix_y = SUM_W'(y_q) + SUM_W'(cy_n);
        end
    end

`ifdef RECT_DRAW_CLIP_EN
    assign pix_vis = (pix_x < SUM_W'(SCREEN_W)) && (pix_y < SUM_W'(SCREEN_H));
`else
    logic unused_clip;
    assign pix_vis     = 1'b1;
    assign unused_clip = ^{pix_x[COORD_W], pix_y[COORD_W], SCREEN_W[0], SCREEN_H[0]};
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        color_d = color_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if ((width_in != '0) && (height_in != '0)) begin
                        x_d     = x_in;
                        y_d     = y_in;
                        w_d     = width_in;
                        h_d     = height_in;
                        cx_d    = '0;
                        cy_d    = '0;
                        color_d = erase ? BG_COLOR : color_in;
                        x_out_d = pix_x[COORD_W-1:0];
                        y_out_d = pix_y[COORD_W-1:0];
                        we_d    = pix_vis;
                        state_d = ST_DRAW;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRAW: begin
                if (last_pix) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cx_d    = cx_n;
                    cy_d    = cy_n;
                    x_out_d = pix_x[COORD_W-1:0];
                    y_out_d = pix_y[COORD_W-1:0];
                    we_d    = pix_vis;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            color_q <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            color_q <= color_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign writeEn = we_q;
    assign x_out   = x_out_q;
    assign y_out   = y_out_q;
    assign color   = color_q;

endmodule

// File: tb/tb_rect_draw.sv
// Randomized self-checking bench for rect_draw against a loop-based pixel-list model.
module tb_rect_draw;

    localparam int SW = 160;
    localparam int SH = 120;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [9:0] x_in, y_in, width_in, height_in;
    logic [2:0] color_in;
    logic       erase;
    logic       busy, done, writeEn;
    logic [9:0] x_out, y_out;
    logic [2:0] color;

    int n_vec;
    int n_err;
    int last_col;

    typedef struct {
        int x;
        int y;
        bit we;
    } pix_t;

    pix_t exp_q[$];

    rect_draw dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .width_in  (width_in),
        .height_in (height_in),
        .color_in  (color_in),
        .erase     (erase),
        .busy      (busy),
        .done      (done),
        .writeEn   (writeEn),
        .x_out     (x_out),
        .y_out     (y_out),
        .color     (color)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference: every pixel of the rectangle, column-major, with screen clipping when enabled
    task automatic build_model(input int x, input int y, input int w, input int h);
        pix_t p;
        exp_q.delete();
        for (int cx = 0; cx < w; cx++) begin
            for (int cy = 0; cy < h; cy++) begin
                p.x = (x + cx) % 1024;
                p.y = (y + cy) % 1024;
`ifdef RECT_DRAW_CLIP_EN
                p.we = ((x + cx) < SW) && ((y + cy) < SH);
`else
                p.we = 1'b1;
`endif
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic scramble_inputs();
        x_in      = 10'($urandom);
        y_in      = 10'($urandom);
        width_in  = 10'($urandom);
        height_in = 10'($urandom);
        color_in  = 3'($urandom);
        erase     = 1'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 2000) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // One request; called at a sample point (#1 after a rising edge) with the DUT idle
    task automatic run_req(input int x, input int y, input int w, input int h,
                           input int col, input bit er, input bit disturb);
        int n;
        wait_idle();
        build_model(x, y, w, h);
        n = w * h;
        if (n > 0) last_col = er ? 0 : col;
        x_in      = 10'(x);
        y_in      = 10'(y);
        width_in  = 10'(w);
        height_in = 10'(h);
        color_in  = 3'(col);
        erase     = er;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        for (int k = 1; k <= n + 1; k++) begin
            start = 1'b0;
            if (k <= n) begin
                check("we", 32'(writeEn), 32'(exp_q[k-1].we));
                if (exp_q[k-1].we) begin
                    check("x_out", 32'(x_out), 32'(exp_q[k-1].x));
                    check("y_out", 32'(y_out), 32'(exp_q[k-1].y));
                end
                check("done_draw", 32'(done), 32'd0);
            end else begin
                check("we_done", 32'(writeEn), 32'd0);
                check("done", 32'(done), 32'd1);
            end
            check("busy", 32'(busy), 32'd1);
            check("color", 32'(color), 32'(last_col));
            if (disturb && k == 2) begin
                scramble_inputs();
                width_in  = 10'd2;
                height_in = 10'd2;
                start     = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("we_idle", 32'(writeEn), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("done_idle", 32'(done), 32'd0);
        check("color_idle", 32'(color), 32'(last_col));
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        last_col = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        x_in = '0; y_in = '0; width_in = '0; height_in = '0;
        color_in = '0; erase = 1'b0;

        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(writeEn), 32'd0);
        check("rst_x", 32'(x_out), 32'd0);
        check("rst_y", 32'(y_out), 32'd0);
        check("rst_color", 32'(color), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_req(10, 20, 3, 2, 5, 1'b0, 1'b0);
        run_req(30, 40, 4, 4, 7, 1'b1, 1'b0);
        run_req(1, 2, 0, 5, 6, 1'b0, 1'b0);
        run_req(50, 60, 2, 2, 3, 1'b0, 1'b1);
        run_req(158, 119, 4, 2, 2, 1'b0, 1'b0);
        run_req(1022, 1021, 4, 5, 4, 1'b0, 1'b0);
        run_req(7, 7, 1, 1, 1, 1'b0, 1'b0);

        // Asynchronous reset after 3 of 9 pixels
        x_in = 10'd5; y_in = 10'd5; width_in = 10'd3; height_in = 10'd3;
        color_in = 3'd6; erase = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("pre_rst_we", 32'(writeEn), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_we", 32'(writeEn), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_x", 32'(x_out), 32'd0);
        check("async_color", 32'(color), 32'd0);
        last_col = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("no_done_after_rst", 32'(done), 32'd0);
        end
        run_req(12, 13, 3, 3, 5, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int rx, ry, rw, rh;
            if ($urandom_range(0, 1) == 0) begin
                rx = int'($urandom_range(0, 170));
                ry = int'($urandom_range(0, 130));
            end else begin
                rx = int'($urandom_range(0, 1023));
                ry = int'($urandom_range(0, 1023));
            end
            rw = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9));
            rh = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9));
            run_req(rx, ry, rw, rh, int'($urandom_range(0, 7)), 1'($urandom),
                    (rw * rh >= 3) && ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
